alt_sync_ram: RTL and testbench

//  Generic true dual-port synchronous RAM (ports A and B) on one clock, with

---
 rtl/alt_sync_ram.sv | 101 ++++++++++
 tb/tb_alt_sync_ram.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alt_sync_ram.sv
// rtl/alt_sync_ram.sv - true dual-port synchronous RAM with byte enables, address stall and optional output registers
// Reads return pre-write array contents; port A wins lane-by-lane when both ports write one word.
module alt_sync_ram #(
  parameter int WIDTH         = 64,
  parameter int WIDTHAD       = 4,
  parameter int NUMWORDS      = 1 << WIDTHAD,
  parameter int WIDTH_BYTEENA = 1,
  parameter int OUTDATA_REG   = 1
) (
  input  logic                     clock0,
  input  logic                     aclr0,
  input  logic                     clocken0,
  input  logic                     wren_a,
  input  logic                     wren_b,
  input  logic                     rden_a,
  input  logic                     rden_b,
  input  logic [WIDTHAD-1:0]       address_a,
  input  logic [WIDTHAD-1:0]       address_b,
  input  logic [WIDTH-1:0]         data_a,
  input  logic [WIDTH-1:0]         data_b,
  input  logic [WIDTH_BYTEENA-1:0] byteena_a,
  input  logic [WIDTH_BYTEENA-1:0] byteena_b,
  input  logic                     addressstall_a,
  input  logic                     addressstall_b,
  output logic [WIDTH-1:0]         q_a,
  output logic [WIDTH-1:0]         q_b
);

  localparam int               LANE  = WIDTH / WIDTH_BYTEENA;
  localparam logic [WIDTHAD:0] LIMIT = NUMWORDS[WIDTHAD:0];

  logic [WIDTH-1:0]   mem [NUMWORDS] = '{default: '0};
  logic [WIDTHAD-1:0] addr_reg_a, addr_reg_b;
  logic [WIDTHAD-1:0] raddr_a, raddr_b;
  logic               wok_a, wok_b, rok_a, rok_b;
  logic [WIDTH-1:0]   rword_a, rword_b;
  logic [WIDTH-1:0]   rdata_a, rdata_b;

  // A stalled port keeps reading through the address it last captured.
  assign raddr_a = addressstall_a ? addr_reg_a : address_a;
  assign raddr_b = addressstall_b ? addr_reg_b : address_b;

  assign wok_a = {1'b0, address_a} < LIMIT;
  assign wok_b = {1'b0, address_b} < LIMIT;
  assign rok_a = {1'b0, raddr_a} < LIMIT;
  assign rok_b = {1'b0, raddr_b} < LIMIT;

  always_comb begin
    rword_a = '0;
    rword_b = '0;
    if (rok_a) rword_a = mem[raddr_a];
    if (rok_b) rword_b = mem[raddr_b];
  end

  // Port B lanes are scheduled first so a colliding port A lane overrides them.
  always_ff @(posedge clock0) begin
    if (clocken0) begin
      for (int i = 0; i < WIDTH_BYTEENA; i++) begin
        if (wren_b && byteena_b[i] && wok_b)
          mem[address_b][i*LANE +: LANE] <= data_b[i*LANE +: LANE];
        if (wren_a && byteena_a[i] && wok_a)
          mem[address_a][i*LANE +: LANE] <= data_a[i*LANE +: LANE];
      end
    end
  end

  always_ff @(posedge clock0) begin
    if (clocken0) begin
      addr_reg_a <= raddr_a;
      addr_reg_b <= raddr_b;
    end
  end

  always_ff @(posedge clock0 or posedge aclr0) begin
    if (aclr0) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (clocken0) begin
      if (rden_a) rdata_a <= rword_a;
      if (rden_b) rdata_b <= rword_b;
    end
  end

  generate
    if (OUTDATA_REG != 0) begin : g_outreg
      always_ff @(posedge clock0 or posedge aclr0) begin
        if (aclr0) begin
          q_a <= '0;
          q_b <= '0;
        end else if (clocken0) begin
          q_a <= rdata_a;
          q_b <= rdata_b;
        end
      end
    end else begin : g_outcomb
      assign q_a = rdata_a;
      assign q_b = rdata_b;
    end
  endgenerate

endmodule

// File: tb/tb_alt_sync_ram.sv
// tb/tb_alt_sync_ram.sv - directed self-checking bench for alt_sync_ram
module tb_alt_sync_ram;

  logic        clock0 = 1'b0;
  logic        aclr0 = 1'b0;
  logic        clocken0 = 1'b1;
  logic        wren_a = 1'b0, wren_b = 1'b0, rden_a = 1'b0, rden_b = 1'b0;
  logic [3:0]  address_a = '0, address_b = '0;
  logic [63:0] data_a = '0, data_b = '0;
  logic [7:0]  byteena_a = 8'hFF, byteena_b = 8'hFF;
  logic        addressstall_a = 1'b0, addressstall_b = 1'b0;
  logic [63:0] q_a, q_b;

  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  ptr = 4'd10;
  int          iter = 0;

  alt_sync_ram #(
    .WIDTH(64), .WIDTHAD(4), .NUMWORDS(16), .WIDTH_BYTEENA(8), .OUTDATA_REG(1)
  ) dut (
    .clock0(clock0), .aclr0(aclr0), .clocken0(clocken0),
    .wren_a(wren_a), .wren_b(wren_b), .rden_a(rden_a), .rden_b(rden_b),
    .address_a(address_a), .address_b(address_b),
    .data_a(data_a), .data_b(data_b),
    .byteena_a(byteena_a), .byteena_b(byteena_b),
    .addressstall_a(addressstall_a), .addressstall_b(addressstall_b),
    .q_a(q_a), .q_b(q_b)
  );

  always #5 clock0 = ~clock0;

  task automatic tick();
    @(posedge clock0);
    #1;
  endtask

  task automatic idle();
    wren_a = 1'b0; wren_b = 1'b0; rden_a = 1'b0; rden_b = 1'b0;
    byteena_a = 8'hFF; byteena_b = 8'hFF;
    addressstall_a = 1'b0; addressstall_b = 1'b0;
    clocken0 = 1'b1;
  endtask

  // One delay-line cycle: write at ptr+5, read at ptr, advance the pointer.
  task automatic ramp_step();
    clocken0 = 1'b1;
    wren_a = 1'b1; byteena_a = 8'hFF;
    address_a = ptr + 4'd5;
    data_a = 64'(iter + 1);
    rden_b = 1'b1;
    address_b = ptr;
    tick();
    ptr = ptr + 4'd1;
    iter = iter + 1;
  endtask

  task automatic test_reset();
    idle();
    #2 aclr0 = 1'b1;
    #1;
    vectors++;
    if (q_a !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_q_a: got %h expected %h", q_a, 64'd0);
    end
    tick();
    tick();
    vectors++;
    if (q_b !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_q_b: got %h expected %h", q_b, 64'd0);
    end
    @(negedge clock0);
    aclr0 = 1'b0;
    tick();
  endtask

  task automatic test_basic_write_read();
    idle();
    wren_a = 1'b1; address_a = 4'd3; data_a = 64'hDEAD_BEEF_0123_4567;
    rden_b = 1'b1; address_b = 4'd3;
    tick();
    wren_a = 1'b0;
    tick();
    vectors++;
    if (q_b !== 64'd0) begin
      miscompares++;
      $display("FAIL basic_latency: got %h expected %h", q_b, 64'd0);
    end
    tick();
    vectors++;
    if (q_b !== 64'hDEAD_BEEF_0123_4567) begin
      miscompares++;
      $display("FAIL basic_read: got %h expected %h", q_b, 64'hDEAD_BEEF_0123_4567);
    end
  endtask

  task automatic test_delay_line();
    idle();
    ptr = 4'd10;
    iter = 0;
    for (int k = 0; k < 24; k++) begin
      ramp_step();
      if (k >= 6) begin
        vectors++;
        if (q_b !== 64'(k - 5)) begin
          miscompares++;
          $display("FAIL delay_line[%0d]: got %h expected %h", k, q_b, 64'(k - 5));
        end
      end
    end
  endtask

  task automatic test_clock_enable();
    logic [3:0] p;
    p = ptr;
    clocken0 = 1'b0;
    wren_a = 1'b1; address_a = p + 4'd1; data_a = 64'hBAD0_BAD0_BAD0_BAD0;
    address_b = p + 4'd3;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (q_b !== 64'(iter - 6)) begin
        miscompares++;
        $display("FAIL clken_freeze[%0d]: got %h expected %h", k, q_b, 64'(iter - 6));
      end
    end
    for (int k = 0; k < 10; k++) begin
      ramp_step();
      vectors++;
      if (q_b !== 64'(iter - 6)) begin
        miscompares++;
        $display("FAIL clken_resume[%0d]: got %h expected %h", k, q_b, 64'(iter - 6));
      end
    end
  endtask

  task automatic test_byteena();
    idle();
    wren_a = 1'b1; address_a = 4'd9; data_a = '1; byteena_a = 8'hFF;
    tick();
    data_a = '0; byteena_a = 8'h0F;
    tick();
    wren_a = 1'b0;
    rden_b = 1'b1; address_b = 4'd9;
    tick();
    tick();
    vectors++;
    if (q_b !== 64'hFFFF_FFFF_0000_0000) begin
      miscompares++;
      $display("FAIL byteena_a: got %h expected %h", q_b, 64'hFFFF_FFFF_0000_0000);
    end
    wren_a = 1'b1; address_a = 4'd10; data_a = '1; byteena_a = 8'hFF;
    tick();
    wren_a = 1'b0;
    wren_b = 1'b1; address_b = 4'd10; data_b = '0; byteena_b = 8'h3C;
    tick();
    wren_b = 1'b0;
    rden_a = 1'b1; address_a = 4'd10;
    tick();
    tick();
    vectors++;
    if (q_a !== 64'hFFFF_0000_0000_FFFF) begin
      miscompares++;
      $display("FAIL byteena_b: got %h expected %h", q_a, 64'hFFFF_0000_0000_FFFF);
    end
  endtask

  task automatic test_collision();
    idle();
    wren_a = 1'b1; address_a = 4'd5; data_a = 64'h11;
    tick();
    data_a = 64'hAA;
    rden_b = 1'b1; address_b = 4'd5;
    tick();
    wren_a = 1'b0;
    tick();
    vectors++;
    if (q_b !== 64'h11) begin
      miscompares++;
      $display("FAIL mixed_rdw_old: got %h expected %h", q_b, 64'h11);
    end
    tick();
    vectors++;
    if (q_b !== 64'hAA) begin
      miscompares++;
      $display("FAIL mixed_rdw_new: got %h expected %h", q_b, 64'hAA);
    end
    wren_a = 1'b1; address_a = 4'd5; data_a = 64'h55; rden_a = 1'b1;
    tick();
    wren_a = 1'b0;
    tick();
    vectors++;
    if (q_a !== 64'hAA) begin
      miscompares++;
      $display("FAIL same_port_rdw: got %h expected %h", q_a, 64'hAA);
    end
    rden_a = 1'b0;
    wren_a = 1'b1; address_a = 4'd6; data_a = 64'h6A;
    wren_b = 1'b1; address_b = 4'd6; data_b = 64'h6B;
    rden_b = 1'b0;
    tick();
    wren_a = 1'b1; address_a = 4'd7; data_a = 64'hAAAA_AAAA_AAAA_AAAA; byteena_a = 8'h0F;
    wren_b = 1'b1; address_b = 4'd7; data_b = 64'hBBBB_BBBB_BBBB_BBBB; byteena_b = 8'hFF;
    tick();
    idle();
    rden_b = 1'b1; address_b = 4'd6;
    tick();
    address_b = 4'd7;
    tick();
    vectors++;
    if (q_b !== 64'h6A) begin
      miscompares++;
      $display("FAIL dual_write_a_wins: got %h expected %h", q_b, 64'h6A);
    end
    tick();
    vectors++;
    if (q_b !== 64'hBBBB_BBBB_AAAA_AAAA) begin
      miscompares++;
      $display("FAIL dual_write_lanes: got %h expected %h", q_b, 64'hBBBB_BBBB_AAAA_AAAA);
    end
  endtask

  task automatic test_async_clear();
    idle();
    rden_b = 1'b1; address_b = 4'd9;
    rden_a = 1'b1; address_a = 4'd7;
    tick();
    tick();
    vectors++;
    if (q_b !== 64'hFFFF_FFFF_0000_0000) begin
      miscompares++;
      $display("FAIL aclr_pre: got %h expected %h", q_b, 64'hFFFF_FFFF_0000_0000);
    end
    #2 aclr0 = 1'b1;
    #1;
    vectors++;
    if (q_b !== 64'd0) begin
      miscompares++;
      $display("FAIL aclr_immediate_q_b: got %h expected %h", q_b, 64'd0);
    end
    vectors++;
    if (q_a !== 64'd0) begin
      miscompares++;
      $display("FAIL aclr_immediate_q_a: got %h expected %h", q_a, 64'd0);
    end
    tick();
    vectors++;
    if (q_b !== 64'd0) begin
      miscompares++;
      $display("FAIL aclr_held: got %h expected %h", q_b, 64'd0);
    end
    @(negedge clock0);
    aclr0 = 1'b0;
    addressstall_b = 1'b1; address_b = 4'd0;
    tick();
    tick();
    vectors++;
    if (q_b !== 64'hFFFF_FFFF_0000_0000) begin
      miscompares++;
      $display("FAIL aclr_after_stall: got %h expected %h", q_b, 64'hFFFF_FFFF_0000_0000);
    end
    vectors++;
    if (q_a !== 64'hBBBB_BBBB_AAAA_AAAA) begin
      miscompares++;
      $display("FAIL aclr_after_q_a: got %h expected %h", q_a, 64'hBBBB_BBBB_AAAA_AAAA);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write_read();
    test_delay_line();
    test_clock_enable();
    test_byteena();
    test_collision();
    test_async_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
